// File: rtl/i2c_sched_pkg.sv
// Shared encodings for the I2C transaction scheduler: engine ops, FSM states,
// frame lengths and the per-step op lookup.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    OP_START     = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ_ACK  = 3'd2,
    OP_READ_NACK = 3'd3,
    OP_STOP      = 3'd4
  } m_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH,
    S_ABORT
  } state_t;

  localparam logic [3:0] WR_STEPS  = 4'd7;
  localparam logic [3:0] RD_STEPS  = 4'd14;
  localparam logic [3:0] RD_OPCODE = 4'hA;

  function automatic logic is_read(input logic [7:0] cmd);
    return cmd[7:4] == RD_OPCODE;
  endfunction

  // Read frames reuse steps 0-6 as the register-pointer write frame.
  function automatic m_op_t step_op(input logic [3:0] s);
    case (s)
      4'd0, 4'd7:                          step_op = OP_START;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8:  step_op = OP_WRITE;
      4'd9, 4'd10, 4'd11:                  step_op = OP_READ_ACK;
      4'd12:                               step_op = OP_READ_NACK;
      default:                             step_op = OP_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the priority
// pointer; the pointer moves past the winner when the grant is accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr, i)]) begin
        grant                   = '0;
        grant[wrap_idx(ptr, i)] = 1'b1;
        grant_idx               = wrap_idx(ptr, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)      ptr <= '0;
    else if (accept) ptr <= wrap_idx(grant_idx, 1);
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares one byte-level I2C master engine between requesters and sequences the
// fixed 4-byte command frames (plus 4-byte readback for 0xAx opcodes).
module i2c_txn_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int          NUM_REQ  = 3,
  parameter logic [6:0]  SLV_ADDR = 7'h55,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  req_cmd,
  input  logic [24*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic                  m_valid,
  output logic [2:0]            m_op,
  output logic [7:0]            m_tx,
  input  logic                  m_ready,
  input  logic                  m_done,
  input  logic [7:0]            m_rx,
  input  logic                  m_nack
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [3:0]         step;
  logic [15:0]        wd;
  logic [7:0]         cmd_q;
  logic [23:0]        data_q;
  logic [31:0]        rx_shift;
  logic               nack_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_accept;
  logic [7:0]         win_cmd;
  logic [23:0]        win_data;
  logic               last_step;
  logic               wd_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .accept    (arb_accept),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  assign arb_accept = (state == S_GRANT) && (|req);
  assign win_cmd    = req_cmd[8*arb_idx +: 8];
  assign win_data   = req_data[24*arb_idx +: 24];
  assign last_step  = step == ((is_read(cmd_q) ? RD_STEPS : WR_STEPS) - 4'd1);
  assign wd_expired = wd >= TIMEOUT - 16'd1;

  function automatic logic [7:0] step_tx(input logic [3:0] s, input logic [7:0] c,
                                         input logic [23:0] d);
    case (s)
      4'd1:    step_tx = {SLV_ADDR, 1'b0};
      4'd2:    step_tx = c;
      4'd3:    step_tx = d[23:16];
      4'd4:    step_tx = d[15:8];
      4'd5:    step_tx = d[7:0];
      4'd8:    step_tx = {SLV_ADDR, 1'b1};
      default: step_tx = 8'h00;
    endcase
  endfunction

  // The command for the next step is loaded on the way into ISSUE so each
  // step costs ISSUE, WAIT, NEXT when the engine is fast.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every branch sees
    // the pre-edge values of step, wd and m_op.
    if (!reset) begin
      state    <= S_IDLE;
      step     <= '0;
      wd       <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m_op     <= '0;
      m_tx     <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      rx_shift <= '0;
      nack_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_GRANT;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (|req) begin
            gnt      <= arb_gnt;
            cmd_q    <= win_cmd;
            data_q   <= win_data;
            step     <= '0;
            wd       <= '0;
            rx_shift <= '0;
            nack_q   <= 1'b0;
            m_valid  <= 1'b1;
            m_op     <= step_op(4'd0);
            m_tx     <= step_tx(4'd0, win_cmd, win_data);
            state    <= S_ISSUE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            wd      <= wd + 16'd1;
            state   <= S_WAIT;
          end else if (wd_expired) begin
            m_op  <= OP_STOP;
            m_tx  <= 8'h00;
            wd    <= '0;
            state <= S_ABORT;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        S_WAIT: begin
          if (m_done) begin
            nack_q <= m_nack && (m_op == OP_WRITE);
            if (m_op == OP_READ_ACK || m_op == OP_READ_NACK)
              rx_shift <= {rx_shift[23:0], m_rx};
            state <= S_NEXT;
          end else if (wd_expired) begin
            m_valid <= 1'b1;
            m_op    <= OP_STOP;
            m_tx    <= 8'h00;
            wd      <= '0;
            state   <= S_ABORT;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        S_NEXT: begin
          if (nack_q) begin
            m_valid <= 1'b1;
            m_op    <= OP_STOP;
            m_tx    <= 8'h00;
            wd      <= '0;
            state   <= S_ABORT;
          end else if (last_step) begin
            done    <= gnt;
            err     <= 1'b0;
            rd_data <= rx_shift;
            state   <= S_FINISH;
          end else begin
            step    <= step + 4'd1;
            m_valid <= 1'b1;
            m_op    <= step_op(step + 4'd1);
            m_tx    <= step_tx(step + 4'd1, cmd_q, data_q);
            wd      <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ABORT: begin
          // Once STOP is accepted, its completion or the watchdog ends the abort.
          if ((!m_valid && m_done) || wd_expired) begin
            m_valid <= 1'b0;
            done    <= gnt;
            err     <= 1'b1;
            rd_data <= rx_shift;
            state   <= S_FINISH;
          end else begin
            wd <= wd + 16'd1;
            if (m_valid && m_ready) m_valid <= 1'b0;
          end
        end
        S_FINISH: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a behavioural byte-engine model
// that logs every accepted op and answers one cycle after acceptance.
module tb_i2c_txn_scheduler;

  localparam int NREQ = 3;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_cmd;
  logic [24*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [31:0]       rd_data;
  logic              busy;
  logic              m_valid;
  logic [2:0]        m_op;
  logic [7:0]        m_tx;
  logic              m_ready;
  logic              m_done;
  logic [7:0]        m_rx;
  logic              m_nack;

  i2c_txn_scheduler #(
    .NUM_REQ  (NREQ),
    .SLV_ADDR (7'h55),
    .TIMEOUT  (16'd20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rd_data  (rd_data),
    .busy     (busy),
    .m_valid  (m_valid),
    .m_op     (m_op),
    .m_tx     (m_tx),
    .m_ready  (m_ready),
    .m_done   (m_done),
    .m_rx     (m_rx),
    .m_nack   (m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] op_log [$];
  logic [10:0] exp_q  [$];
  logic [7:0]  rx_q   [$];
  logic        stall = 1'b0;
  logic        nack_addr = 1'b0;
  logic        pend = 1'b0;
  logic [2:0]  pend_op;
  logic [7:0]  pend_tx;
  int          gnt_cyc;
  logic        got_err;
  logic [31:0] got_rd;
  int          order [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Engine model: accepts on m_valid&m_ready, pulses m_done one cycle later.
  initial begin
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_rx    = 8'h00;
    m_nack  = 1'b0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      m_nack = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else if (pend) begin
        m_done = 1'b1;
        if (pend_op == 3'd2 || pend_op == 3'd3)
          m_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        if (pend_op == 3'd1) m_nack = nack_addr && (pend_tx == 8'hAA);
        pend = 1'b0;
      end
      m_ready = !stall && reset;
      if (reset && m_valid && m_ready) begin
        pend    = 1'b1;
        pend_op = m_op;
        pend_tx = m_tx;
        op_log.push_back({m_op, (m_op == 3'd1) ? m_tx : 8'h00});
      end
    end
  end

  task automatic ex(input logic [2:0] op, input logic [7:0] tx);
    exp_q.push_back({op, tx});
  endtask

  task automatic ex_wr_frame(input logic [7:0] cmd, input logic [23:0] d);
    ex(3'd0, 8'h00); ex(3'd1, 8'hAA); ex(3'd1, cmd);
    ex(3'd1, d[23:16]); ex(3'd1, d[15:8]); ex(3'd1, d[7:0]); ex(3'd4, 8'h00);
  endtask

  task automatic ex_rd_frame();
    ex(3'd0, 8'h00); ex(3'd1, 8'hAB); ex(3'd2, 8'h00); ex(3'd2, 8'h00);
    ex(3'd2, 8'h00); ex(3'd3, 8'h00); ex(3'd4, 8'h00);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nops"}, 32'(op_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < op_log.size())
        check($sformatf("%s_op%0d", tag, i), 32'(op_log[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where done[idx] is seen.
  task automatic run_txn(input string tag, input int idx, input logic [7:0] cmd,
                         input logic [23:0] data, output int cyc);
    req_cmd[8*idx +: 8]   = cmd;
    req_data[24*idx +: 24] = data;
    op_log.delete();
    req[idx] = 1'b1;
    cyc      = 0;
    gnt_cyc  = -1;
    while (done[idx] !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt[idx] === 1'b1 && gnt_cyc < 0) gnt_cyc = cyc;
    end
    check({tag, "_done"}, 32'(done[idx]), 32'd1);
    got_err  = err;
    got_rd   = rd_data;
    req[idx] = 1'b0;
  endtask

  task automatic collect(input int n, output int got);
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] === 1'b1) begin
          if (got < 4) order[got] = i;
          got++;
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int got;
    int v_cyc;
    int a_cyc;
    int unstable;

    req      = '0;
    req_cmd  = '0;
    req_data = '0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_op", 32'(m_op), 32'd0);
    check("rst_m_tx", 32'(m_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Plain write from requester 0.
    ex_wr_frame(8'h01, 24'h070000);
    run_txn("wr", 0, 8'h01, 24'h070000, cyc);
    check("wr_cycles", 32'(cyc), 32'd23);
    check("wr_gnt_latency", 32'(gnt_cyc), 32'd2);
    check("wr_err", 32'(got_err), 32'd0);
    check_log("wr");
    @(negedge clk);
    check("wr_done_once", 32'(done), 32'd0);
    check("wr_gnt_dropped", 32'(gnt), 32'd0);
    check("wr_busy_idle", 32'(busy), 32'd0);

    // Read from requester 1.
    rx_q.delete();
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    ex_wr_frame(8'hA1, 24'h000000);
    ex_rd_frame();
    run_txn("rd", 1, 8'hA1, 24'h000000, cyc);
    check("rd_cycles", 32'(cyc), 32'd44);
    check("rd_data", got_rd, 32'h11223344);
    check("rd_err", 32'(got_err), 32'd0);
    check_log("rd");
    @(negedge clk);

    // Address NACK aborts straight to STOP.
    nack_addr = 1'b1;
    ex(3'd0, 8'h00); ex(3'd1, 8'hAA); ex(3'd4, 8'h00);
    run_txn("nack", 2, 8'h20, 24'h010203, cyc);
    check("nack_err", 32'(got_err), 32'd1);
    check_log("nack");
    nack_addr = 1'b0;
    @(negedge clk);

    // Engine never ready: watchdog abort, then the STOP stalls too.
    stall = 1'b1;
    op_log.delete();
    req_cmd[7:0] = 8'h12;
    req[0]   = 1'b1;
    cyc      = 0;
    v_cyc    = -1;
    a_cyc    = -1;
    unstable = 0;
    while (done[0] !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (m_valid && v_cyc < 0) v_cyc = cyc;
      if (m_valid && m_op == 3'd4 && a_cyc < 0) a_cyc = cyc;
      if (m_valid && a_cyc < 0 && (m_op != 3'd0 || m_tx != 8'h00)) unstable++;
    end
    req[0] = 1'b0;
    check("to_done", 32'(done[0]), 32'd1);
    check("to_abort_delay", 32'(a_cyc - v_cyc), 32'd20);
    check("to_bound", 32'(cyc <= 2 * 20 + 4), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_held_stable", 32'(unstable), 32'd0);
    check("to_no_handshake", 32'(op_log.size()), 32'd0);
    stall = 1'b0;
    @(negedge clk);

    // Reset in the middle of the read frame.
    rx_q.delete();
    req_cmd[15:8] = 8'hA2;
    req[1] = 1'b1;
    cyc    = 0;
    while (!(cyc >= 27 && m_valid === 1'b1) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("rm_reached_read_frame", 32'(cyc < 300), 32'd1);
    reset  = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    check("rm_m_valid", 32'(m_valid), 32'd0);
    check("rm_gnt", 32'(gnt), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    rx_q.delete();
    rx_q.push_back(8'h5A); rx_q.push_back(8'hA5);
    rx_q.push_back(8'hC3); rx_q.push_back(8'h3C);
    ex_wr_frame(8'hA2, 24'h000000);
    ex_rd_frame();
    run_txn("rm_rd", 1, 8'hA2, 24'h000000, cyc);
    check("rm_rd_data", got_rd, 32'h5AA5C33C);
    check("rm_rd_err", 32'(got_err), 32'd0);
    check_log("rm_rd");
    @(negedge clk);

    // Round-robin order from a fresh pointer.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req_cmd  = {8'h13, 8'h12, 8'h11};
    req_data = '0;
    req      = 3'b111;
    collect(3, got);
    check("rr_count3", 32'(got), 32'd3);
    check("rr_first", 32'(order[0]), 32'd0);
    check("rr_second", 32'(order[1]), 32'd1);
    check("rr_third", 32'(order[2]), 32'd2);
    @(negedge clk);
    req = 3'b101;
    collect(2, got);
    check("rr_count2", 32'(got), 32'd2);
    check("rr_wrap_first", 32'(order[0]), 32'd0);
    check("rr_wrap_second", 32'(order[1]), 32'd2);
    @(negedge clk);

    // Dropping req after grant still completes the transaction.
    req[2] = 1'b1;
    cyc    = 0;
    while (gnt[2] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    req[2] = 1'b0;
    cyc    = 0;
    while (done[2] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drop_req_done", 32'(done[2]), 32'd1);
    check("drop_req_err", 32'(err), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
